// File: rtl/startup_reset_sequencer.sv
// SoC start-up sequencer: PLL lock filter, then ordered release of GSR, GTS, peripheral and core resets.
// Optional lock-timeout watchdog enabled by defining RSTSEQ_LOCK_TIMEOUT_EN.
module startup_reset_sequencer #(
  parameter int LOCK_FILTER  = 4,
  parameter int ROC_CYCLES   = 16,
  parameter int TOC_CYCLES   = 4,
  parameter int PERIPH_DLY   = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       gsr_o,
  output logic       gts_o,
  output logic       periph_rst_o,
  output logic       core_rst_o,
  output logic       seq_done_o,
  output logic [1:0] reset_cause_o,
  output logic       lock_timeout_o
);

  localparam int MAX_AB   = (LOCK_FILTER > ROC_CYCLES) ? LOCK_FILTER : ROC_CYCLES;
  localparam int MAX_CD   = (TOC_CYCLES > PERIPH_DLY) ? TOC_CYCLES : PERIPH_DLY;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_P    = (LOCK_TIMEOUT > MAX_ABCD) ? LOCK_TIMEOUT : MAX_ABCD;
  localparam int CW       = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] C_FILTER   = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] C_ROC_LAST = CW'(ROC_CYCLES - 1);
  localparam logic [CW-1:0] C_TOC_LAST = CW'(TOC_CYCLES - 1);
  localparam logic [CW-1:0] C_PER_LAST = CW'(PERIPH_DLY - 1);

  localparam logic [1:0] CAUSE_LOCK_LOSS = 2'b01;
  localparam logic [1:0] CAUSE_SW        = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_GSR_HOLD,
    S_GTS_HOLD,
    S_PERIPH_REL,
    S_RUN
  } state_t;

  logic          r_sync_meta;
  logic          r_lock_sync;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic          r_gsr, r_gts, r_periph, r_core, r_done;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_cause_next;
  logic          w_lock_loss;
  logic          w_gsr, w_gts, w_periph, w_core, w_done;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] C_TIMEOUT     = CW'(LOCK_TIMEOUT);
  localparam logic [1:0]    CAUSE_TIMEOUT = 2'b11;
  logic [CW-1:0] r_to_cnt;
  logic          r_to_flag;
  logic [CW-1:0] w_to_cnt_next;
  logic          w_to_flag_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_sync_meta <= pll_locked;
      r_lock_sync <= r_sync_meta;
    end
  end

  assign w_lock_loss = (r_state != S_WAIT_LOCK) && !r_lock_sync;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cause_next = r_cause;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    w_to_cnt_next  = r_to_cnt;
    w_to_flag_next = r_to_flag;
`endif
    // Lock loss outranks a software request arriving in the same cycle.
    if (w_lock_loss) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
      w_cause_next = CAUSE_LOCK_LOSS;
    end else if (sw_reset_req && (r_state != S_WAIT_LOCK)) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
      w_cause_next = CAUSE_SW;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
          if (r_to_cnt >= C_TIMEOUT) begin
            w_to_cnt_next  = '0;
            w_to_flag_next = 1'b1;
            w_cause_next   = CAUSE_TIMEOUT;
          end else begin
            w_to_cnt_next = r_to_cnt + CW'(1);
          end
`endif
          // Leave once LOCK_FILTER consecutive synchronized lock samples were counted.
          if (r_cnt >= C_FILTER) begin
            w_state_next = S_GSR_HOLD;
            w_cnt_next   = '0;
          end else if (r_lock_sync) begin
            w_cnt_next = r_cnt + CW'(1);
          end else begin
            w_cnt_next = '0;
          end
        end
        S_GSR_HOLD: begin
          if (r_cnt >= C_ROC_LAST) begin
            w_state_next = S_GTS_HOLD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_GTS_HOLD: begin
          if (r_cnt >= C_TOC_LAST) begin
            w_state_next = S_PERIPH_REL;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_PERIPH_REL: begin
          if (r_cnt >= C_PER_LAST) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_RUN:   w_cnt_next = '0;
        default: begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end
      endcase
    end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    if (w_state_next != S_WAIT_LOCK) w_to_cnt_next = '0;
`endif
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_gsr    = 1'b1;
    w_gts    = 1'b1;
    w_periph = 1'b1;
    w_core   = 1'b1;
    w_done   = 1'b0;
    case (w_state_next)
      S_GTS_HOLD:   w_gsr = 1'b0;
      S_PERIPH_REL: begin
        w_gsr    = 1'b0;
        w_gts    = 1'b0;
        w_periph = 1'b0;
      end
      S_RUN: begin
        w_gsr    = 1'b0;
        w_gts    = 1'b0;
        w_periph = 1'b0;
        w_core   = 1'b0;
        w_done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_WAIT_LOCK;
      r_cnt    <= '0;
      r_cause  <= 2'b00;
      r_gsr    <= 1'b1;
      r_gts    <= 1'b1;
      r_periph <= 1'b1;
      r_core   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_cause  <= w_cause_next;
      r_gsr    <= w_gsr;
      r_gts    <= w_gts;
      r_periph <= w_periph;
      r_core   <= w_core;
      r_done   <= w_done;
    end
  end

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      r_to_cnt  <= w_to_cnt_next;
      r_to_flag <= w_to_flag_next;
    end
  end
  assign lock_timeout_o = r_to_flag;
`else
  assign lock_timeout_o = 1'b0;
`endif

  assign gsr_o         = r_gsr;
  assign gts_o         = r_gts;
  assign periph_rst_o  = r_periph;
  assign core_rst_o    = r_core;
  assign seq_done_o    = r_done;
  assign reset_cause_o = r_cause;

endmodule

// File: tb/tb_startup_reset_sequencer.sv
// Directed bench for startup_reset_sequencer: POR timing, lock filter, lock loss, software reset,
// async reset mid-sequence and (with RSTSEQ_LOCK_TIMEOUT_EN) the lock-timeout watchdog.
module tb_startup_reset_sequencer;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam int LT = 16;
`else
  localparam int LT = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       gsr_o, gts_o, periph_rst_o, core_rst_o, seq_done_o, lock_timeout_o;
  logic [1:0] reset_cause_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc;

  always #5 clk = ~clk;

  startup_reset_sequencer #(
    .LOCK_FILTER (4),
    .ROC_CYCLES  (16),
    .TOC_CYCLES  (4),
    .PERIPH_DLY  (8),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_reset_req  (sw_reset_req),
    .gsr_o         (gsr_o),
    .gts_o         (gts_o),
    .periph_rst_o  (periph_rst_o),
    .core_rst_o    (core_rst_o),
    .seq_done_o    (seq_done_o),
    .reset_cause_o (reset_cause_o),
    .lock_timeout_o(lock_timeout_o)
  );

  wire [4:0] vec = {gsr_o, gts_o, periph_rst_o, core_rst_o, seq_done_o};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected {gsr,gts,periph,core,done} rel cycles after entering WAIT_LOCK with lock already synchronized:
  // 4 filter counts, GSR_HOLD from rel 5, GTS_HOLD from 21, PERIPH_REL from 25, RUN from 33.
  function automatic logic [4:0] exp_vec(input int rel);
    if (rel < 21) return 5'b11110;
    if (rel < 25) return 5'b01110;
    if (rel < 33) return 5'b00010;
    return 5'b00001;
  endfunction

  // After this, the next rising edge is cycle 0.
  task automatic do_por(input logic lock);
    rst          = 1'b1;
    pll_locked   = lock;
    sw_reset_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; sw_reset_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (vec !== 5'b11110) begin
      $display("FAIL reset_outputs: got %b want 11110", vec); tests_failed++;
    end
    tests_run++;
    if (reset_cause_o !== 2'b00 || lock_timeout_o !== 1'b0) begin
      $display("FAIL reset_cause: got cause=%b to=%b want 00/0", reset_cause_o, lock_timeout_o); tests_failed++;
    end
    $display("[TB] test_reset done");
  endtask

  // POR with lock held: gsr falls at 22, gts/periph at 26, core/done at 34 (equivalent entry rel offset 1).
  task automatic test_por_sequence();
    do_por(1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      tests_run++;
      if (vec !== exp_vec(cyc - 1)) begin
        $display("FAIL por_seq cycle %0d: got %b want %b", cyc, vec, exp_vec(cyc - 1)); tests_failed++;
      end
    end
    tests_run++;
    if (reset_cause_o !== 2'b00) begin
      $display("FAIL por_cause: got %b want 00", reset_cause_o); tests_failed++;
    end
    $display("[TB] test_por_sequence done");
  endtask

  task automatic test_lock_filter();
    do_por(1'b0);
    for (int i = 0; i < 45; i++) begin
      pll_locked = (i % 3) != 2;
      tick();
      tests_run++;
      if (vec !== 5'b11110) begin
        $display("FAIL lock_filter cycle %0d: got %b want 11110", cyc, vec); tests_failed++;
      end
    end
    pll_locked = 1'b1;
    repeat (40) tick();
    tests_run++;
    if (seq_done_o !== 1'b1) begin
      $display("FAIL lock_filter_recover: got done=%b want 1", seq_done_o); tests_failed++;
    end
    $display("[TB] test_lock_filter done");
  endtask

  task automatic test_lock_loss();
    int e;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tests_run++;
    if (vec !== 5'b00001) begin
      $display("FAIL lock_loss_pre: got %b want 00001", vec); tests_failed++;
    end
    tick();
    tests_run++;
    if (vec !== 5'b11110 || reset_cause_o !== 2'b01) begin
      $display("FAIL lock_loss_hit: got %b cause=%b want 11110 cause=01", vec, reset_cause_o); tests_failed++;
    end
    e = cyc;
    for (int i = 0; i < 35; i++) begin
      tick();
      tests_run++;
      if (vec !== exp_vec(cyc - e)) begin
        $display("FAIL lock_loss_rerun rel %0d: got %b want %b", cyc - e, vec, exp_vec(cyc - e)); tests_failed++;
      end
    end
    $display("[TB] test_lock_loss done");
  endtask

  task automatic test_sw_reset();
    int e;
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    tests_run++;
    if (vec !== 5'b11110 || reset_cause_o !== 2'b10) begin
      $display("FAIL sw_reset_hit: got %b cause=%b want 11110 cause=10", vec, reset_cause_o); tests_failed++;
    end
    e = cyc;
    for (int i = 0; i < 35; i++) begin
      tick();
      tests_run++;
      if (vec !== exp_vec(cyc - e)) begin
        $display("FAIL sw_reset_rerun rel %0d: got %b want %b", cyc - e, vec, exp_vec(cyc - e)); tests_failed++;
      end
    end
    $display("[TB] test_sw_reset done");
  endtask

  task automatic test_lock_loss_vs_sw_then_async_rst();
    int e;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    tests_run++;
    if (vec !== 5'b11110 || reset_cause_o !== 2'b01) begin
      $display("FAIL coincident_cause: got %b cause=%b want 11110 cause=01", vec, reset_cause_o); tests_failed++;
    end
    e = cyc;
    while (cyc < e + 22) tick();
    tests_run++;
    if (vec !== 5'b01110) begin
      $display("FAIL gts_hold_reached: got %b want 01110", vec); tests_failed++;
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (vec !== 5'b11110 || reset_cause_o !== 2'b00 || lock_timeout_o !== 1'b0) begin
      $display("FAIL async_rst: got %b cause=%b to=%b want 11110 cause=00 to=0", vec, reset_cause_o, lock_timeout_o);
      tests_failed++;
    end
    @(posedge clk);
    #3 rst = 1'b0;
    $display("[TB] test_lock_loss_vs_sw_then_async_rst done");
  endtask

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  task automatic test_lock_timeout();
    int budget;
    do_por(1'b0);
    while (cyc < 15) tick();
    tests_run++;
    if (lock_timeout_o !== 1'b0) begin
      $display("FAIL timeout_early: got %b want 0 at cycle 15", lock_timeout_o); tests_failed++;
    end
    tick();
    tests_run++;
    if (lock_timeout_o !== 1'b1 || reset_cause_o !== 2'b11) begin
      $display("FAIL timeout_fire: got to=%b cause=%b want 1/11", lock_timeout_o, reset_cause_o); tests_failed++;
    end
    pll_locked = 1'b1;
    budget = 0;
    while (seq_done_o !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    tests_run++;
    if (seq_done_o !== 1'b1 || lock_timeout_o !== 1'b1 || reset_cause_o !== 2'b11) begin
      $display("FAIL timeout_complete: got done=%b to=%b cause=%b want 1/1/11", seq_done_o, lock_timeout_o, reset_cause_o);
      tests_failed++;
    end
    $display("[TB] test_lock_timeout done");
  endtask
`else
  task automatic test_lock_timeout();
    do_por(1'b0);
    repeat (60) tick();
    tests_run++;
    if (lock_timeout_o !== 1'b0 || reset_cause_o !== 2'b00 || vec !== 5'b11110) begin
      $display("FAIL no_timeout: got to=%b cause=%b out=%b want 0/00/11110", lock_timeout_o, reset_cause_o, vec);
      tests_failed++;
    end
    $display("[TB] test_lock_timeout done");
  endtask
`endif

  initial begin
    cyc = 0;
    test_reset();
    test_por_sequence();
    test_lock_loss();
    test_sw_reset();
    test_lock_loss_vs_sw_then_async_rst();
    test_lock_filter();
    test_lock_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
